// File: rtl/freq_meter.sv
// freq_meter: gated edge counter. Counts rising edges of a slow asynchronous
// input over fixed windows of GATE_CYCLES clk cycles and reports each count
// with a one-cycle valid strobe plus a range/overflow verdict.
module freq_meter #(
  parameter int unsigned      GATE_CYCLES = 16000000,
  parameter int unsigned      CNT_W       = 32,
  parameter logic [CNT_W-1:0] LOW_LIMIT   = '0,
  parameter logic [CNT_W-1:0] HIGH_LIMIT  = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             sig_in,
  output logic [CNT_W-1:0] count_out,
  output logic             count_valid,
  output logic             in_range,
  output logic             overflow,
  output logic             busy
);

  localparam int unsigned      GATE_W    = $clog2(GATE_CYCLES);
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  typedef enum logic {IDLE, MEASURE} state_t;

  state_t             state;
  logic [GATE_W-1:0]  gate_cnt;
  logic [CNT_W-1:0]   edge_cnt;
  logic               ovf;

  logic               sync_meta;
  logic               sync_sig;
  logic               sync_prev;
  logic               rise;

  logic               at_max;
  logic [CNT_W-1:0]   edge_next;
  logic               ovf_next;
  logic               low_ok;
  logic               high_ok;
  logic               window_ok;

  // Two-flop synchroniser plus a history flop; runs in every state so a level
  // that is already high when measuring starts never looks like an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta <= 1'b0;
      sync_sig  <= 1'b0;
      sync_prev <= 1'b0;
    end else begin
      sync_meta <= sig_in;
      sync_sig  <= sync_meta;
      sync_prev <= sync_sig;
    end
  end

  assign rise = sync_sig & ~sync_prev;

  // Saturating next edge count, including any rise seen this cycle.
  always_comb begin
    at_max    = (edge_cnt == CNT_MAX);
    edge_next = edge_cnt;
    if (rise && !at_max) begin
      edge_next = edge_cnt + CNT_W'(1);
    end
    ovf_next  = ovf | (rise & at_max);
  end

  // Limit checks collapse to constants when a limit spans the whole range.
  if (LOW_LIMIT == '0) begin : g_low_any
    assign low_ok = 1'b1;
  end else begin : g_low_cmp
    assign low_ok = (edge_next >= LOW_LIMIT);
  end

  if (HIGH_LIMIT == CNT_MAX) begin : g_high_any
    assign high_ok = 1'b1;
  end else begin : g_high_cmp
    assign high_ok = (edge_next <= HIGH_LIMIT);
  end

  assign window_ok = !ovf_next && low_ok && high_ok;

  // Measurement FSM: back-to-back windows while enabled, result latched on the
  // final gate cycle, abort to IDLE without touching the results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      gate_cnt    <= '0;
      edge_cnt    <= '0;
      ovf         <= 1'b0;
      count_out   <= '0;
      count_valid <= 1'b0;
      in_range    <= 1'b0;
      overflow    <= 1'b0;
      busy        <= 1'b0;
    end else begin
      count_valid <= 1'b0;
      case (state)
        IDLE: begin
          gate_cnt <= '0;
          edge_cnt <= '0;
          ovf      <= 1'b0;
          if (enable) begin
            state <= MEASURE;
            busy  <= 1'b1;
          end
        end
        MEASURE: begin
          if (!enable) begin
            state    <= IDLE;
            busy     <= 1'b0;
            gate_cnt <= '0;
            edge_cnt <= '0;
            ovf      <= 1'b0;
          end else if (gate_cnt == GATE_LAST) begin
            count_out   <= edge_next;
            overflow    <= ovf_next;
            in_range    <= window_ok;
            count_valid <= 1'b1;
            gate_cnt    <= '0;
            edge_cnt    <= '0;
            ovf         <= 1'b0;
          end else begin
            gate_cnt <= gate_cnt + GATE_W'(1);
            edge_cnt <= edge_next;
            ovf      <= ovf_next;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_freq_meter.sv
// tb_freq_meter: directed checks of freq_meter using three instances with
// different parameter sets sharing one clock and reset.
module tb_freq_meter;

  logic clk;
  logic rst_n;

  logic        en_a, sig_a, valid_a, inr_a, ovf_a, busy_a;
  logic [31:0] count_a;
  logic        en_b, sig_b, valid_b, inr_b, ovf_b, busy_b;
  logic [31:0] count_b;
  logic        en_c, sig_c, valid_c, inr_c, ovf_c, busy_c;
  logic [3:0]  count_c;

  int tests_run;
  int tests_failed;

  freq_meter #(.GATE_CYCLES(100), .CNT_W(32), .LOW_LIMIT(32'd9), .HIGH_LIMIT(32'd11)) dut_a (
    .clk(clk), .rst_n(rst_n), .enable(en_a), .sig_in(sig_a),
    .count_out(count_a), .count_valid(valid_a), .in_range(inr_a),
    .overflow(ovf_a), .busy(busy_a)
  );

  freq_meter #(.GATE_CYCLES(50), .CNT_W(32), .LOW_LIMIT(32'd1)) dut_b (
    .clk(clk), .rst_n(rst_n), .enable(en_b), .sig_in(sig_b),
    .count_out(count_b), .count_valid(valid_b), .in_range(inr_b),
    .overflow(ovf_b), .busy(busy_b)
  );

  freq_meter #(.GATE_CYCLES(100), .CNT_W(4)) dut_c (
    .clk(clk), .rst_n(rst_n), .enable(en_c), .sig_in(sig_c),
    .count_out(count_c), .count_valid(valid_c), .in_range(inr_c),
    .overflow(ovf_c), .busy(busy_c)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en_a = 0; en_b = 0; en_c = 0;
    sig_a = 0; sig_b = 0; sig_c = 0;
    repeat (3) tick();
    tests_run++;
    if ({count_a, valid_a, inr_a, ovf_a, busy_a} !== 36'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_a: got %h expected 0", {count_a, valid_a, inr_a, ovf_a, busy_a});
    end
    tests_run++;
    if ({count_b, valid_b, inr_b, ovf_b, busy_b} !== 36'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_b: got %h expected 0", {count_b, valid_b, inr_b, ovf_b, busy_b});
    end
    tests_run++;
    if ({count_c, valid_c, inr_c, ovf_c, busy_c} !== 8'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_c: got %h expected 0", {count_c, valid_c, inr_c, ovf_c, busy_c});
    end
    rst_n = 1'b1;
    repeat (3) tick();
  endtask

  // Period-10 input, three windows of 100 cycles: ten edges each.
  task automatic test_periodic();
    int pulses;
    pulses = 0;
    sig_a = 1'b1;
    en_a  = 1'b1;
    for (int k = 1; k <= 301; k++) begin
      tick();
      if (valid_a) begin
        pulses++;
        tests_run++;
        if (k != pulses * 100 + 1) begin
          tests_failed++;
          $display("[TB] FAIL periodic_valid_cycle: got %0d expected %0d", k, pulses * 100 + 1);
        end
        tests_run++;
        if (count_a !== 32'd10 || inr_a !== 1'b1 || ovf_a !== 1'b0) begin
          tests_failed++;
          $display("[TB] FAIL periodic_result: got count=%0d inr=%b ovf=%b expected 10 1 0",
                   count_a, inr_a, ovf_a);
        end
      end
      sig_a = ((k % 10) < 5);
    end
    tests_run++;
    if (pulses != 3) begin
      tests_failed++;
      $display("[TB] FAIL periodic_pulses: got %0d expected 3", pulses);
    end
    en_a  = 1'b0;
    sig_a = 1'b0;
    repeat (5) tick();
  endtask

  // Input already high when enabled, never toggles: no edge counted.
  task automatic test_held_high();
    int pulses;
    pulses = 0;
    sig_b = 1'b1;
    repeat (5) tick();
    en_b = 1'b1;
    for (int k = 1; k <= 51; k++) begin
      tick();
      if (valid_b) begin
        pulses++;
        tests_run++;
        if (k != 51) begin
          tests_failed++;
          $display("[TB] FAIL held_valid_cycle: got %0d expected 51", k);
        end
        tests_run++;
        if (count_b !== 32'd0 || inr_b !== 1'b0 || ovf_b !== 1'b0) begin
          tests_failed++;
          $display("[TB] FAIL held_result: got count=%0d inr=%b ovf=%b expected 0 0 0",
                   count_b, inr_b, ovf_b);
        end
      end
    end
    tests_run++;
    if (pulses != 1) begin
      tests_failed++;
      $display("[TB] FAIL held_pulses: got %0d expected 1", pulses);
    end
    en_b  = 1'b0;
    sig_b = 1'b0;
    repeat (5) tick();
  endtask

  // 4-bit counter: fast input saturates, then a slow window of 5 edges.
  task automatic test_overflow();
    int pulses;
    pulses = 0;
    sig_c = 1'b1;
    en_c  = 1'b1;
    for (int k = 1; k <= 201; k++) begin
      tick();
      if (valid_c) begin
        pulses++;
        if (pulses == 1) begin
          tests_run++;
          if (k != 101 || count_c !== 4'd15 || ovf_c !== 1'b1 || inr_c !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL overflow_w1: got k=%0d count=%0d ovf=%b inr=%b expected 101 15 1 0",
                     k, count_c, ovf_c, inr_c);
          end
        end else begin
          tests_run++;
          if (k != 201 || count_c !== 4'd5 || ovf_c !== 1'b0 || inr_c !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL overflow_w2: got k=%0d count=%0d ovf=%b inr=%b expected 201 5 0 1",
                     k, count_c, ovf_c, inr_c);
          end
        end
      end
      if (k < 95)       sig_c = ((k % 4) < 2);
      else if (k < 101) sig_c = 1'b0;
      else              sig_c = (((k - 101) % 20) < 10);
    end
    tests_run++;
    if (pulses != 2) begin
      tests_failed++;
      $display("[TB] FAIL overflow_pulses: got %0d expected 2", pulses);
    end
    en_c  = 1'b0;
    sig_c = 1'b0;
    repeat (5) tick();
  endtask

  // Rises landing on the last gate cycle of window 1 and the first gate cycle
  // of window 3 are attributed to exactly one window each.
  task automatic test_boundary();
    int pulses;
    int total;
    int exp_cnt[3];
    exp_cnt = '{2, 1, 2};
    pulses = 0;
    total  = 0;
    sig_a = 1'b0;
    en_a  = 1'b1;
    for (int k = 1; k <= 301; k++) begin
      tick();
      if (valid_a) begin
        tests_run++;
        if (pulses < 3 && (count_a !== 32'(exp_cnt[pulses]) || inr_a !== 1'b0)) begin
          tests_failed++;
          $display("[TB] FAIL boundary_w%0d: got count=%0d inr=%b expected %0d 0",
                   pulses + 1, count_a, inr_a, exp_cnt[pulses]);
        end
        total += int'(count_a);
        pulses++;
      end
      sig_a = (k == 40 || k == 41 || k == 98 || k == 99 || k == 150 || k == 151 ||
               k == 199 || k == 200 || k == 250 || k == 251);
    end
    tests_run++;
    if (pulses != 3 || total != 5) begin
      tests_failed++;
      $display("[TB] FAIL boundary_total: got pulses=%0d total=%0d expected 3 5", pulses, total);
    end
    en_a  = 1'b0;
    sig_a = 1'b0;
    repeat (5) tick();
  endtask

  // Abort at gate_cnt 60 keeps the previous result; re-enable gives a full window.
  task automatic test_abort();
    int pulses;
    int first;
    pulses = 0;
    first  = 0;
    sig_a = 1'b1;
    en_a  = 1'b1;
    for (int k = 1; k <= 61; k++) begin
      tick();
      if (valid_a) pulses++;
      sig_a = ((k % 10) < 5);
    end
    tests_run++;
    if (busy_a !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL abort_busy_before: got %b expected 1", busy_a);
    end
    en_a = 1'b0;
    tick();
    tests_run++;
    if (busy_a !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL abort_busy_after: got %b expected 0", busy_a);
    end
    sig_a = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (valid_a) pulses++;
    end
    tests_run++;
    if (pulses != 0 || count_a !== 32'd2 || inr_a !== 1'b0 || ovf_a !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL abort_hold: got pulses=%0d count=%0d inr=%b ovf=%b expected 0 2 0 0",
               pulses, count_a, inr_a, ovf_a);
    end
    sig_a = 1'b1;
    en_a  = 1'b1;
    for (int k = 1; k <= 101; k++) begin
      tick();
      if (valid_a && first == 0) begin
        first = k;
        tests_run++;
        if (count_a !== 32'd10 || inr_a !== 1'b1) begin
          tests_failed++;
          $display("[TB] FAIL abort_restart_result: got count=%0d inr=%b expected 10 1", count_a, inr_a);
        end
      end
      sig_a = ((k % 10) < 5);
    end
    tests_run++;
    if (first != 101) begin
      tests_failed++;
      $display("[TB] FAIL abort_restart_cycle: got %0d expected 101", first);
    end
  endtask

  // Asynchronous reset in the middle of a running window.
  task automatic test_async_reset();
    int first;
    int pulses;
    first  = 0;
    pulses = 0;
    for (int k = 1; k <= 50; k++) begin
      tick();
      sig_a = ((k % 10) < 5);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({count_a, valid_a, inr_a, ovf_a, busy_a} !== 36'd0) begin
      tests_failed++;
      $display("[TB] FAIL async_reset_outputs: got %h expected 0", {count_a, valid_a, inr_a, ovf_a, busy_a});
    end
    sig_a = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (valid_a || busy_a) pulses++;
    end
    tests_run++;
    if (pulses != 0) begin
      tests_failed++;
      $display("[TB] FAIL async_reset_hold: got %0d active cycles expected 0", pulses);
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 101; k++) begin
      tick();
      if (valid_a && first == 0) first = k;
    end
    tests_run++;
    if (first != 101 || count_a !== 32'd0 || inr_a !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL async_reset_restart: got k=%0d count=%0d inr=%b expected 101 0 0",
               first, count_a, inr_a);
    end
    en_a = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_periodic();
    test_held_high();
    test_overflow();
    test_boundary();
    test_abort();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
